// File: rtl/d3s_adc_acq_buffer_if.sv
// Wishbone classic register bus between a host master and the D3S ADC
// acquisition buffer. Signal names are written from the slave's point of view.
interface d3s_adc_acq_buffer_if;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/d3s_adc_acq_buffer.sv
// Single-shot ADC capture buffer with a Wishbone register slave.
// The host writes START, the next g_size samples land in RAM, READY rises,
// and the host then reads samples back through ACQ_ADDR / ACQ_DATA.
// Optional build macro D3S_ACQ_SAMPLE_COUNT_EN adds the read-only
// ACQ_COUNT register at word address 3 (otherwise that address reads 0).
module d3s_adc_acq_buffer #(
  parameter int g_size       = 2048,
  parameter int g_data_width = 16
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic [g_data_width-1:0] adc_data_i,
  input  logic                    adc_valid_i,
  d3s_adc_acq_buffer_if.slave     wb,
  output logic                    acq_busy_o
);

  localparam int c_aw = (g_size > 1) ? $clog2(g_size) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } t_state;

  t_state                  r_state;
  t_state                  w_state_next;
  logic [c_aw-1:0]         r_wr_ptr;
  logic [c_aw-1:0]         r_acq_addr;
  logic                    r_ready;
  logic [g_data_width-1:0] r_ram [0:g_size-1];
  logic [g_data_width-1:0] r_ram_q;
  logic                    r_stage1;
  logic                    r_ack;
  logic [1:0]              r_adr_d1;
  logic                    r_we_d1;
  logic [31:0]             r_dat_o;

  logic        w_take;
  logic        w_wr;
  logic        w_start;
  logic        w_store;
  logic        w_last;
  logic [31:0] w_rd_data;
  logic [31:0] w_reg3;

  // A new access is only accepted once the previous one has fully acked.
  assign w_take  = wb.wb_cyc_i & wb.wb_stb_i & ~r_stage1 & ~r_ack;
  assign w_wr    = w_take & wb.wb_we_i;
  assign w_start = w_wr & (wb.wb_adr_i == 2'd0) & wb.wb_dat_i[0];
  // A START in the same cycle as a sample wins, so that sample is dropped.
  assign w_store = (r_state == ACQ) & adc_valid_i & ~w_start;
  assign w_last  = (r_wr_ptr == c_aw'(g_size - 1));

  assign acq_busy_o    = (r_state == ACQ);
  assign wb.wb_ack_o   = r_ack;
  assign wb.wb_dat_o   = r_dat_o;
  assign wb.wb_stall_o = 1'b0;

  // Byte selects are ignored and upper data bits are only partly used.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, wb.wb_sel_i, wb.wb_dat_i};

  // State register for the acquisition FSM.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: START always (re)enters ACQ, the last stored sample ends it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = ACQ;
      ACQ: begin
        if (w_start)               w_state_next = ACQ;
        else if (w_store && w_last) w_state_next = DONE;
      end
      DONE:    if (w_start) w_state_next = ACQ;
      default: w_state_next = IDLE;
    endcase
  end

  // Write pointer and READY flag; the pointer stops at the last location.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_ready  <= 1'b0;
    end else if (w_start) begin
      r_wr_ptr <= '0;
      r_ready  <= 1'b0;
    end else if (w_store) begin
      if (w_last) r_ready  <= 1'b1;
      else        r_wr_ptr <= r_wr_ptr + c_aw'(1);
    end
  end

  // Sample RAM with a registered read port addressed by ACQ_ADDR.
  always_ff @(posedge clk_sys_i) begin
    if (w_store) r_ram[r_wr_ptr] <= adc_data_i;
    r_ram_q <= r_ram[r_acq_addr];
  end

  // ACQ_ADDR register keeps only the bits that address the RAM.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i)                         r_acq_addr <= '0;
    else if (w_wr && wb.wb_adr_i == 2'd1) r_acq_addr <= wb.wb_dat_i[c_aw-1:0];
  end

`ifdef D3S_ACQ_SAMPLE_COUNT_EN
  localparam logic [16:0] c_size17 = 17'(g_size);
  logic [16:0] r_count;

  // Samples stored since the last START, saturating at the buffer size.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i)                           r_count <= '0;
    else if (w_start)                       r_count <= '0;
    else if (w_store && r_count < c_size17) r_count <= r_count + 17'd1;
  end

  assign w_reg3 = 32'(r_count);
`else
  assign w_reg3 = '0;
`endif

  // Read data mux, evaluated one cycle after the access so the RAM word is ready.
  always_comb begin
    w_rd_data = '0;
    case (r_adr_d1)
      2'd0:    w_rd_data = {30'b0, r_ready, 1'b0};
      2'd1:    w_rd_data = 32'(r_acq_addr);
      2'd2:    w_rd_data = 32'(r_ram_q);
      default: w_rd_data = w_reg3;
    endcase
  end

  // Two-stage ack pipeline: ack and read data appear two cycles after the take.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stage1 <= 1'b0;
      r_ack    <= 1'b0;
      r_adr_d1 <= '0;
      r_we_d1  <= 1'b0;
      r_dat_o  <= '0;
    end else begin
      r_stage1 <= w_take;
      r_ack    <= r_stage1;
      if (w_take) begin
        r_adr_d1 <= wb.wb_adr_i;
        r_we_d1  <= wb.wb_we_i;
      end
      if (r_stage1 && !r_we_d1) r_dat_o <= w_rd_data;
      else                      r_dat_o <= '0;
    end
  end

endmodule

// File: tb/tb_d3s_adc_acq_buffer.sv
// Self-checking bench for d3s_adc_acq_buffer. Expected read data is pushed
// to a scoreboard queue when each read is issued and popped when it acks.
// Compile with +define+D3S_ACQ_SAMPLE_COUNT_EN to exercise ACQ_COUNT.
module tb_d3s_adc_acq_buffer;
  localparam int G_SIZE = 2048;
  localparam int DW     = 16;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [DW-1:0] adcData  = '0;
  logic          adcValid = 1'b0;
  logic          busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] expQ[$];

  d3s_adc_acq_buffer_if wbIf();

  d3s_adc_acq_buffer #(.g_size(G_SIZE), .g_data_width(DW)) dut (
    .clk_sys_i  (clk),
    .rst_n_i    (rst_n),
    .adc_data_i (adcData),
    .adc_valid_i(adcValid),
    .wb         (wbIf),
    .acq_busy_o (busy)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One bus access, entered and left at posedge+1; bounded wait for the ack.
  task automatic wb_access(input logic we, input logic [1:0] adr, input logic [31:0] wdata,
                           input bit withSample, output logic [31:0] rdata, output int lat);
    bit seen = 0;
    wbIf.wb_cyc_i = 1'b1;
    wbIf.wb_stb_i = 1'b1;
    wbIf.wb_we_i  = we;
    wbIf.wb_adr_i = adr;
    wbIf.wb_dat_i = wdata;
    wbIf.wb_sel_i = 4'hF;
    if (withSample) adcValid = 1'b1;
    lat   = -1;
    rdata = '0;
    for (int n = 1; n <= 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (withSample) adcValid = 1'b0;
      if (wbIf.wb_ack_o === 1'b1) begin
        seen  = 1;
        lat   = n;
        rdata = wbIf.wb_dat_o;
      end
    end
    wbIf.wb_cyc_i = 1'b0;
    wbIf.wb_stb_i = 1'b0;
    wbIf.wb_we_i  = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL ack_timeout adr=%0d: no ack within 10 cycles, required one", adr);
    end else begin
      @(posedge clk); #1;
      if (wbIf.wb_ack_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ack_width adr=%0d: ack=%b one cycle later, required 0", adr, wbIf.wb_ack_o);
      end
    end
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] wdata);
    logic [31:0] d;
    int l;
    wb_access(1'b1, adr, wdata, 1'b0, d, l);
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] rdata, output int lat);
    wb_access(1'b0, adr, 32'h0, 1'b0, rdata, lat);
  endtask

  // Streams n samples, one per cycle, and counts cycles where busy was low.
  task automatic feed_samples(input int n, input logic [DW-1:0] base, input bit incr, output int busyLow);
    busyLow = 0;
    for (int i = 0; i < n; i++) begin
      adcData  = incr ? DW'(base + DW'(i)) : base;
      adcValid = 1'b1;
      if (busy !== 1'b1) busyLow++;
      @(posedge clk); #1;
    end
    adcValid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || wbIf.wb_ack_o !== 1'b0 || wbIf.wb_dat_o !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b ack=%b dat=%h, required 0/0/0", busy, wbIf.wb_ack_o, wbIf.wb_dat_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      expQ.push_back(32'h0);
      wb_read(2'(a), rd, lat);
      ex = expQ.pop_front();
      if (a != 2) begin
        checks++;
        if (rd !== ex) begin
          errors++;
          $display("[TB] FAIL reset_read adr=%0d: got %h, required %h", a, rd, ex);
        end
      end
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("[TB] FAIL ack_latency adr=%0d: got %0d cycles, required 2", a, lat);
      end
    end
  endtask

  task automatic test_capture();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    int busyLow;
    wb_write(2'd0, 32'h1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %b, required 1", busy);
    end
    expQ.push_back(32'h0);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL cr_during_acq: got %h, required %h", rd, ex);
    end
    feed_samples(G_SIZE, 16'h0100, 1'b1, busyLow);
    checks++;
    if (busyLow !== 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_capture: low during capture %0d times, busy after=%b, required 0 and 0", busyLow, busy);
    end
    expQ.push_back(32'h2);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL cr_ready: got %h, required %h", rd, ex);
    end
    // Samples after DONE must be ignored.
    feed_samples(5, 16'hDEAD, 1'b0, busyLow);
    wb_write(2'd1, 32'h0);
    expQ.push_back(32'h100);
    wb_read(2'd2, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL post_done_ignored: got %h, required %h", rd, ex);
    end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    for (int i = 0; i < 128; i++) begin
      wb_write(2'd1, 32'(i));
      expQ.push_back(32'h100 + 32'(i));
      wb_read(2'd2, rd, lat);
      ex = expQ.pop_front();
      checks++;
      if (rd !== ex) begin
        errors++;
        $display("[TB] FAIL readback idx=%0d: got %h, required %h", i, rd, ex);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    wb_write(2'd1, 32'(G_SIZE + 5));
    expQ.push_back(32'd5);
    wb_read(2'd1, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL addr_truncate: got %h, required %h", rd, ex);
    end
    expQ.push_back(32'h105);
    wb_read(2'd2, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL addr_truncate_data: got %h, required %h", rd, ex);
    end
  endtask

  task automatic test_restart();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    int busyLow;
    int bad = 0;
    wb_write(2'd0, 32'h1);
    feed_samples(10, 16'h1111, 1'b0, busyLow);
    checks++;
    if (busyLow !== 0) begin
      errors++;
      $display("[TB] FAIL busy_first_run: low %0d times, required 0", busyLow);
    end
    // Restart with a sample arriving in the same cycle: that sample is dropped.
    adcData = 16'h2222;
    wb_access(1'b1, 2'd0, 32'h1, 1'b1, rd, lat);
    feed_samples(G_SIZE - 1, 16'hBEEF, 1'b0, busyLow);
    expQ.push_back(32'h0);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_not_ready: cr=%h busy=%b, required %h and 1", rd, busy, ex);
    end
    feed_samples(1, 16'hBEEF, 1'b0, busyLow);
    expQ.push_back(32'h2);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL restart_ready: got %h, required %h", rd, ex);
    end
    for (int i = 0; i < G_SIZE; i++) begin
      wb_write(2'd1, 32'(i));
      expQ.push_back(32'hBEEF);
      wb_read(2'd2, rd, lat);
      ex = expQ.pop_front();
      if (rd !== ex) bad++;
      if (rd !== ex && bad <= 8) $display("[TB] FAIL restart_data idx=%0d: got %h, required %h", i, rd, ex);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL restart_data_total: %0d wrong locations, required 0", bad);
    end
  endtask

  task automatic test_count();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    int busyLow;
`ifdef D3S_ACQ_SAMPLE_COUNT_EN
    wb_write(2'd0, 32'h1);
    feed_samples(37, 16'h0, 1'b1, busyLow);
    expQ.push_back(32'd37);
    wb_read(2'd3, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL count_partial: got %0d, required %0d", rd, ex);
    end
    feed_samples(G_SIZE - 37 + 3, 16'h0, 1'b1, busyLow);
    expQ.push_back(32'(G_SIZE));
    wb_read(2'd3, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL count_full: got %0d, required %0d", rd, ex);
    end
`else
    wb_write(2'd3, 32'hFFFF_FFFF);
    expQ.push_back(32'h0);
    wb_read(2'd3, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL reg3_zero: got %h, required %h", rd, ex);
    end
    expQ.push_back(32'h2);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL reg3_write_ignored: cr=%h, required %h", rd, ex);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic [31:0] ex;
    int lat;
    int busyLow;
    wb_write(2'd1, 32'd9);
    wb_write(2'd0, 32'h1);
    feed_samples(20, 16'h0, 1'b1, busyLow);
    rst_n = 1'b0;
    #3;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_busy: got %b, required 0", busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expQ.push_back(32'h0);
    wb_read(2'd0, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL reset_mid_cr: got %h, required %h", rd, ex);
    end
    expQ.push_back(32'h0);
    wb_read(2'd1, rd, lat);
    ex = expQ.pop_front();
    checks++;
    if (rd !== ex) begin
      errors++;
      $display("[TB] FAIL reset_mid_addr: got %h, required %h", rd, ex);
    end
  endtask

  initial begin
    wbIf.wb_cyc_i = 1'b0;
    wbIf.wb_stb_i = 1'b0;
    wbIf.wb_we_i  = 1'b0;
    wbIf.wb_adr_i = '0;
    wbIf.wb_dat_i = '0;
    wbIf.wb_sel_i = '0;
    #1;
    $display("[TB] starting");
    test_reset();
    test_capture();
    test_readback();
    test_addr_wrap();
    test_restart();
    test_count();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
